timebase_scheduler: RTL and testbench
=====================================

# timebase_scheduler

Shared timebase controller for the board's 50 MHz input clock. A single prescaler is divided down to a base strobe. The strobe drives NCH independently programmed channel dividers, each producing a one-cycle tick and a square wave. Channels are configured at run time through a valid/ready write port. The block replaces per-feature free-running dividers: slow-logic consumers (display refresh, debounce, 1 Hz counters) request a channel rather than instantiating their own counter.

## Interface
- BASE_DIV, 50000: prescaler period in cin cycles. Base strobe is 1 kHz at 50 MHz. Legal range ≥ 2.
- NCH, 4: number of channels. Legal range 2..8.
- W, 16: channel divisor / counter width.
- cin  in  1  system clock. Single clock domain; all logic on posedge cin.
- rst_n  in  1  reset, asynchronous assert, active-low. Release is synchronous to cin, provided upstream.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  block can accept a config write.
- cfg_ch  in  $clog2(NCH)  target channel. Values ≥ NCH are accepted and ignored.
- cfg_div  in  W  channel divisor, in base strobes.
- cfg_en  in  1  channel enable.
- base_tick  out  1  one-cycle pulse per prescaler period.
- tick  out  NCH  per-channel one-cycle pulse per channel period.
- sq  out  NCH  per-channel square wave.

## Operation
- Reset (rst_n low, immediate):
  - Prescaler count pcnt = 0.
  - All channel div = 0, en = 0, ccnt = 0.
  - base_tick = 0, tick = 0, sq = 0, cfg_ready = 0.
  - cfg_ready rises on the first cin edge after release.
- Prescaler:
  - pcnt increments modulo BASE_DIV.
  - The strobe is internal condition `strb` = (pcnt == BASE_DIV-1).
  - base_tick is registered: it is high for the cycle following the edge at which strb was true.
- Channel c advances only on strb edges, and only when en=1 and div ≥ 1:
  - If ccnt == div-1: ccnt ← 0 and tick[c] ← 1.
  - Otherwise: ccnt ← ccnt+1.
  - tick[c] is 0 on every other edge.
- sq[c] is registered: sq[c] ← 1 when en=1, div ≥ 1, and next ccnt ≥ div>>1; otherwise 0.
  - Low for the first floor(div/2) base periods, high for the rest.
  - div=1: sq stays 1.
- Disabled channel, or div=0: ccnt held 0, tick 0, sq 0. Other channels are unaffected.
- Config handshake (FSM states IDLE, APPLY):
  - IDLE: cfg_ready=1. A write transfers when cfg_valid && cfg_ready.
  - On transfer: latch ch/div/en into a pending register, go to APPLY, cfg_ready=0.
  - APPLY (exactly one cycle): target channel gets div/en, ccnt ← 0, tick ← 0, sq ← 0, then return to IDLE.
  - Sustained throughput is one write per 2 cycles.
- Simultaneous events:
  - APPLY on a strb edge: the target channel takes the APPLY values and does not advance or tick. All other channels advance normally.
  - Rewriting a running channel always restarts its period from ccnt=0.
- Arithmetic: all counters wrap-free by construction (ccnt < div ≤ 2^W-1); no saturation logic needed.
- Reset asserted mid-write: pending write is discarded, FSM returns to IDLE after release.

## Timing
- Latency, cfg transfer edge to new config in effect: 2 edges (transfer, then APPLY).
- First tick after a write applying div=D: the D-th strb edge after APPLY, provided no further rewrite intervenes.
- From the end of reset, the first base_tick is high in cycle BASE_DIV, counting the first post-release edge as edge 1.
- tick[c] coincides exactly with a base_tick cycle.
- Outputs are registered: no combinational path from cfg_* to tick, sq or base_tick. cfg_ready depends only on state.
- cfg_valid may be held high continuously. Inputs are sampled only when cfg_ready=1.

## Test plan
All scenarios use BASE_DIV=4, NCH=4, W=8.
- Reset and base strobe: deassert rst_n, then run 20 cycles -> base_tick high exactly on cycles 4, 8, 12, 16, 20; tick=0, sq=0, cfg_ready=1 from cycle 1.
- Divisor 3: write ch0 div=3 en=1 -> cfg_ready low for one cycle; tick[0] on every 3rd base_tick; sq[0] low for 1 base period, high for 2, repeating.
- Edge divisors: ch1 div=1 -> tick[1] on every base_tick and sq[1] constant 1; ch2 div=0 en=1 -> tick[2]=0 and sq[2]=0 forever.
- Write collision: time APPLY for ch0 onto a strb edge -> no tick[0] that cycle, ch0 restarts from 0; ch1 ticks unaffected in the same cycle.
- Back-to-back writes: cfg_valid held high with 3 different writes -> accepted on alternate cycles, each applied in order; write with cfg_ch=3 while NCH=4 is honoured, and cfg_ch ≥ NCH (with NCH=3) is accepted with no state change.
- Reset mid-operation: pull rst_n low during APPLY with channels running -> all outputs 0 immediately; after release, channels disabled and cfg_ready=1.

Source files
------------

// File: rtl/timebase_scheduler.sv
// Shared timebase: one prescaler produces a base strobe, and NCH run-time
// programmable channel dividers turn it into per-channel ticks and square waves.
// Channels are written through a two-state valid/ready config port.

// One channel divider. Counts base strobes; a config write restarts the period.
module tbs_channel #(
    parameter int W = 16
) (
    input  logic         cin,
    input  logic         rst_n,
    input  logic         strb,
    input  logic         wr,
    input  logic [W-1:0] wdiv,
    input  logic         wen,
    output logic         tick,
    output logic         sq
);

    logic [W-1:0] div;
    logic         en;
    logic [W-1:0] ccnt;
    logic [W-1:0] ccnt_nxt;
    logic         run;
    logic         wrap;

    // Next count: advance only on a strobe while enabled with a nonzero divisor
    always_comb begin
        run      = en && (div != '0);
        wrap     = (ccnt == div - W'(1));
        ccnt_nxt = ccnt;
        if (run && strb)
            ccnt_nxt = wrap ? '0 : ccnt + W'(1);
    end

    // Channel state; a write wins over a coincident strobe and restarts at 0
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            en   <= 1'b0;
            ccnt <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (wr) begin
            div  <= wdiv;
            en   <= wen;
            ccnt <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else begin
            ccnt <= ccnt_nxt;
            tick <= run && strb && wrap;
            // low for the first div/2 base periods, high for the remainder
            sq   <= run && (ccnt_nxt >= (div >> 1));
        end
    end

endmodule

module timebase_scheduler #(
    parameter int BASE_DIV = 50000,
    parameter int NCH      = 4,
    parameter int W        = 16
) (
    input  logic                   cin,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [W-1:0]           cfg_div,
    input  logic                   cfg_en,
    output logic                   base_tick,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         sq
);

    localparam int PW = $clog2(BASE_DIV);
    localparam int CW = $clog2(NCH);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           up;
    logic           apply;
    logic [PW-1:0]  pcnt;
    logic           strb;
    logic [CW-1:0]  pch;
    logic [W-1:0]   pdiv;
    logic           pen;

    assign strb = (pcnt == PW'(BASE_DIV - 1));

    // Prescaler and registered base strobe
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            pcnt      <= '0;
            base_tick <= 1'b0;
        end else begin
            pcnt      <= strb ? '0 : pcnt + PW'(1);
            base_tick <= strb;
        end
    end

    // Config FSM state; 'up' holds cfg_ready low until the first edge after reset
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            up    <= 1'b0;
        end else begin
            state <= state_nxt;
            up    <= 1'b1;
        end
    end

    // Config FSM next state and outputs; ready is a function of state only
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = up;
                if (cfg_valid && up)
                    state_nxt = APPLY;
            end
            APPLY: begin
                apply     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending write, captured on transfer and consumed in APPLY
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            pch  <= '0;
            pdiv <= '0;
            pen  <= 1'b0;
        end else if (cfg_valid && cfg_ready) begin
            pch  <= cfg_ch;
            pdiv <= cfg_div;
            pen  <= cfg_en;
        end
    end

    // Channel array; a pending channel index >= NCH matches no instance
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        tbs_channel #(.W(W)) u_ch (
            .cin   (cin),
            .rst_n (rst_n),
            .strb  (strb),
            .wr    (apply && (pch == CW'(c))),
            .wdiv  (pdiv),
            .wen   (pen),
            .tick  (tick[c]),
            .sq    (sq[c])
        );
    end

endmodule

// File: tb/tb_timebase_scheduler.sv
// Scoreboard bench: stimulus pushes the expected tick/sq pattern for each
// base_tick; a monitor pops and compares whenever base_tick is presented.
module tb_timebase_scheduler;

    logic       cin = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_en = 1'b0;
    logic       base_tick;
    logic [3:0] tick;
    logic [3:0] sq;

    // NCH=3 instance for out-of-range channel writes
    logic       c3_valid = 1'b0;
    logic       c3_ready;
    logic [1:0] c3_ch = '0;
    logic [7:0] c3_div = '0;
    logic       c3_en = 1'b0;
    logic       c3_base;
    logic [2:0] c3_tick;
    logic [2:0] c3_sq;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [3:0] tk;
        logic [3:0] s;
    } exp_t;

    exp_t q[$];
    exp_t r;

    timebase_scheduler #(.BASE_DIV(4), .NCH(4), .W(8)) u_dut (
        .cin(cin), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
        .base_tick(base_tick), .tick(tick), .sq(sq)
    );

    timebase_scheduler #(.BASE_DIV(4), .NCH(3), .W(8)) u_dut3 (
        .cin(cin), .rst_n(rst_n), .cfg_valid(c3_valid), .cfg_ready(c3_ready),
        .cfg_ch(c3_ch), .cfg_div(c3_div), .cfg_en(c3_en),
        .base_tick(c3_base), .tick(c3_tick), .sq(c3_sq)
    );

    always #5 cin = ~cin;

    // cycle n = the interval after the n-th posedge following reset release
    always @(posedge cin or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] t, input logic [3:0] s);
        exp_t e;
        e.cyc = c;
        e.tk  = t;
        e.s   = s;
        q.push_back(e);
    endtask

    task automatic wait_to(input int n);
        do @(negedge cin); while (cyc < n);
    endtask

    // Single write issued at a negedge; returns at the negedge of the APPLY cycle
    task automatic wr(input logic [1:0] ch, input logic [7:0] dv, input logic e);
        logic acc;
        acc = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_en    = e;
        for (int i = 0; i < 8; i++) begin
            acc = cfg_ready;
            @(posedge cin);
            if (acc) break;
            @(negedge cin);
        end
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL wr_timeout: got ready=0 want ready=1 within 8 cycles");
        end
        @(negedge cin);
        cfg_valid = 1'b0;
        chk("ready_low_in_apply", cfg_ready, 0);
    endtask

    // Monitor: every base_tick consumes one expectation; ticks elsewhere are errors
    always @(negedge cin) begin
        if (rst_n) begin
            if (base_tick) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_base_tick: got base_tick at cyc %0d want none", cyc);
                end else begin
                    r = q.pop_front();
                    chk("base_tick_cycle", cyc, r.cyc);
                    chk("tick", {28'd0, tick}, {28'd0, r.tk});
                    chk("sq", {28'd0, sq}, {28'd0, r.s});
                end
            end else begin
                chk("tick_off_strobe", {28'd0, tick}, 0);
            end
        end
    end

    initial begin
        logic [1:0] bch [3];
        logic [7:0] bdv [3];
        logic       ben [3];
        bch = '{2'd3, 2'd1, 2'd2};
        bdv = '{8'd2, 8'd0, 8'd4};
        ben = '{1'b1, 1'b0, 1'b1};

        // reset state
        repeat (3) @(negedge cin);
        chk("rst_base_tick", base_tick, 0);
        chk("rst_tick", {28'd0, tick}, 0);
        chk("rst_sq", {28'd0, sq}, 0);
        chk("rst_ready", cfg_ready, 0);

        // base strobe every 4 cycles, channels idle
        for (int c = 4; c <= 20; c += 4) push(c, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        chk("ready_before_edge1", cfg_ready, 0);
        wait_to(1);
        chk("ready_cycle1", cfg_ready, 1);
        chk("c3_ready_cycle1", c3_ready, 1);

        // ch0 div=3, ch1 div=1, ch2 div=0 enabled
        push(24, 4'b0000, 4'b0001);
        push(28, 4'b0010, 4'b0011);
        push(32, 4'b0011, 4'b0010);
        push(36, 4'b0010, 4'b0011);
        push(40, 4'b0010, 4'b0011);
        push(44, 4'b0011, 4'b0010);
        push(48, 4'b0010, 4'b0011);
        push(52, 4'b0010, 4'b0011);
        wait_to(20);
        wr(2'd0, 8'd3, 1'b1);
        wait_to(22);
        chk("ready_back_after_apply", cfg_ready, 1);
        wait_to(25);
        wr(2'd1, 8'd1, 1'b1);
        wait_to(29);
        wr(2'd2, 8'd0, 1'b1);

        // rewrite ch0 with APPLY on the strobe edge 56 where it would have ticked
        push(56, 4'b0010, 4'b0010);
        push(60, 4'b0010, 4'b0011);
        push(64, 4'b0010, 4'b0011);
        push(68, 4'b0011, 4'b0010);
        wait_to(54);
        wr(2'd0, 8'd3, 1'b1);

        // back-to-back: ch3 div=2, ch1 off, ch2 div=4 with valid held high
        push(72, 4'b0010, 4'b1011);
        push(76, 4'b1000, 4'b0001);
        push(80, 4'b0001, 4'b1100);
        push(84, 4'b1000, 4'b0101);
        push(88, 4'b0100, 4'b1001);
        push(92, 4'b1001, 4'b0000);
        push(96, 4'b0000, 4'b1101);
        wait_to(69);
        cfg_valid = 1'b1;
        cfg_ch = bch[0]; cfg_div = bdv[0]; cfg_en = ben[0];
        for (int k = 0; k < 7; k++) begin
            chk("b2b_ready", cfg_ready, (k % 2 == 0) ? 1 : 0);
            if (k == 1) begin cfg_ch = bch[1]; cfg_div = bdv[1]; cfg_en = ben[1]; end
            if (k == 3) begin cfg_ch = bch[2]; cfg_div = bdv[2]; cfg_en = ben[2]; end
            if (k == 5) cfg_valid = 1'b0;
            @(negedge cin);
        end

        // reset asserted while a write sits in APPLY
        wait_to(97);
        cfg_valid = 1'b1;
        cfg_ch = 2'd3; cfg_div = 8'd5; cfg_en = 1'b1;
        @(negedge cin);
        chk("pre_reset_apply_ready", cfg_ready, 0);
        chk("pre_reset_sq", {28'd0, sq}, 32'h0000_000d);
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("mid_rst_base_tick", base_tick, 0);
        chk("mid_rst_tick", {28'd0, tick}, 0);
        chk("mid_rst_sq", {28'd0, sq}, 0);
        chk("mid_rst_ready", cfg_ready, 0);
        repeat (2) @(negedge cin);
        for (int c = 4; c <= 20; c += 4) push(c, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        wait_to(1);
        chk("ready_after_rst", cfg_ready, 1);

        // NCH=3: write to channel 3 is taken but changes nothing
        wait_to(2);
        c3_valid = 1'b1;
        c3_ch = 2'd3; c3_div = 8'd1; c3_en = 1'b1;
        @(negedge cin);
        c3_valid = 1'b0;
        chk("c3_accepted", c3_ready, 0);
        wait_to(4);
        chk("c3_ready_again", c3_ready, 1);
        chk("c3_base_tick", c3_base, 1);
        for (int c = 4; c <= 20; c++) begin
            chk("c3_tick_zero", {29'd0, c3_tick}, 0);
            chk("c3_sq_zero", {29'd0, c3_sq}, 0);
            @(negedge cin);
        end

        wait_to(21);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
